rule_scan_scheduler: RTL and testbench

RULE_SCAN_SCHEDULER -- requirements
Module: rule_scan_scheduler

---
 rtl/rule_scan_scheduler_if.sv | 25 ++
 rtl/rule_scan_scheduler.sv | 118 +++++++++++
 tb/tb_rule_scan_scheduler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rule_scan_scheduler_if.sv
// rule_scan_scheduler_if: start/rule-select/status bundle between controller and scheduler
interface rule_scan_scheduler_if;
  logic       EN_REGRAS;
  logic [5:0] Ativo_UP;
  logic [3:0] Regras;
  logic       rule_valid;
  logic       Reset_inf;
  logic       EN_defuzzy;
  logic       busy;
  logic       done;
  logic       no_fire;
  logic [3:0] n_rules;
`ifdef FUZZY_SCHED_ABORT_EN
  logic       abort;
  modport master (output EN_REGRAS, Ativo_UP, abort,
                  input Regras, rule_valid, Reset_inf, EN_defuzzy, busy, done, no_fire, n_rules);
  modport slave  (input EN_REGRAS, Ativo_UP, abort,
                  output Regras, rule_valid, Reset_inf, EN_defuzzy, busy, done, no_fire, n_rules);
`else
  modport master (output EN_REGRAS, Ativo_UP,
                  input Regras, rule_valid, Reset_inf, EN_defuzzy, busy, done, no_fire, n_rules);
  modport slave  (input EN_REGRAS, Ativo_UP,
                  output Regras, rule_valid, Reset_inf, EN_defuzzy, busy, done, no_fire, n_rules);
`endif
endinterface

// File: rtl/rule_scan_scheduler.sv
// rule_scan_scheduler: scans the 3x3 fuzzy rule grid, presenting active rules to inference; optional abort via FUZZY_SCHED_ABORT_EN
module rule_scan_scheduler #(
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned DEFUZZ_LAT = 3
) (
  input logic clk_0,
  input logic Srst,
  rule_scan_scheduler_if.slave s
);
  typedef enum logic [2:0] {IDLE, CLEAR, SCAN, DEFUZZ, WAIT, DONE} state_t;
  localparam logic [3:0] HLAST = 4'(HOLD_CYC - 1);
  localparam logic [3:0] WLAST = 4'(DEFUZZ_LAT - 1);
  state_t state_q, state_d;
  logic [1:0] rs_q, i1_q, i1_d, i2_q, i2_d;
  logic [3:0] hcnt_q, hcnt_d, wcnt_q, wcnt_d, nr_q, nr_d;
  logic [5:0] act_q, act_d;
  logic [2:0] a1, a2;
  logic nf_q, nf_d, rv_q, rinf_q, edf_q, busy_q, done_q, cur_on, nxt_on, rdy;
  assign rdy    = rs_q[1];
  assign a1     = act_q[2:0];
  assign a2     = act_q[5:3];
  assign cur_on = a1[i1_q] & a2[i2_q];
  assign nxt_on = (state_d == SCAN) & a1[i1_d] & a2[i2_d];
  assign s.Regras     = {i1_q, i2_q};
  assign s.rule_valid = rv_q;
  assign s.Reset_inf  = rinf_q;
  assign s.EN_defuzzy = edf_q;
  assign s.busy       = busy_q;
  assign s.done       = done_q;
  assign s.no_fire    = nf_q;
  assign s.n_rules    = nr_q;
  // two-flop release synchronizer: starts are only honoured once reset release has settled
  always_ff @(posedge clk_0 or negedge Srst)
    if (!Srst) rs_q <= '0;
    else rs_q <= {rs_q[0], 1'b1};
  // next-state: walk combos row-major, dwelling HOLD_CYC cycles on active ones
  always_comb begin
    state_d = state_q;
    i1_d    = i1_q;
    i2_d    = i2_q;
    hcnt_d  = hcnt_q;
    wcnt_d  = wcnt_q;
    act_d   = act_q;
    nf_d    = nf_q;
    nr_d    = nr_q;
    case (state_q)
      IDLE: if (rdy && s.EN_REGRAS) begin
        state_d = CLEAR;
        act_d   = s.Ativo_UP;
        nf_d    = 1'b0;
        nr_d    = '0;
      end
      CLEAR: begin
        state_d = SCAN;
        hcnt_d  = '0;
      end
      SCAN: if (!cur_on || hcnt_q == HLAST) begin
        hcnt_d = '0;
        if (i2_q != 2'd2) i2_d = i2_q + 2'd1;
        else if (i1_q != 2'd2) begin
          i2_d = '0;
          i1_d = i1_q + 2'd1;
        end else begin
          state_d = (nr_q != '0) ? DEFUZZ : DONE;
          nf_d    = (nr_q == '0);
          i1_d    = '0;
          i2_d    = '0;
        end
      end else hcnt_d = hcnt_q + 4'd1;
      DEFUZZ: begin
        state_d = (DEFUZZ_LAT == 0) ? DONE : WAIT;
        wcnt_d  = '0;
      end
      WAIT: if (wcnt_q == WLAST) state_d = DONE;
            else wcnt_d = wcnt_q + 4'd1;
      default: state_d = IDLE;
    endcase
`ifdef FUZZY_SCHED_ABORT_EN
    if (s.abort && state_q != IDLE) begin
      state_d = IDLE;
      i1_d    = '0;
      i2_d    = '0;
      hcnt_d  = '0;
    end
`endif
  end
  // state and registered outputs, all derived from the next state
  always_ff @(posedge clk_0 or negedge Srst)
    if (!Srst) begin
      state_q <= IDLE;
      i1_q    <= '0;
      i2_q    <= '0;
      hcnt_q  <= '0;
      wcnt_q  <= '0;
      act_q   <= '0;
      nf_q    <= 1'b0;
      nr_q    <= '0;
      rv_q    <= 1'b0;
      rinf_q  <= 1'b0;
      edf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      hcnt_q  <= hcnt_d;
      wcnt_q  <= wcnt_d;
      act_q   <= act_d;
      nf_q    <= nf_d;
      nr_q    <= nr_d + {3'b0, nxt_on & (hcnt_d == 4'd0)};
      rv_q    <= nxt_on;
      rinf_q  <= (state_d == CLEAR);
      edf_q   <= (state_d == DEFUZZ);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
endmodule

// File: tb/tb_rule_scan_scheduler.sv
// tb_rule_scan_scheduler: randomized and directed runs checked against a cycle-trace model of the rule scan
module tb_rule_scan_scheduler;
  localparam int HOLD = 2;
  localparam int LAT  = 3;
  logic clk_0 = 1'b0;
  logic Srst  = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [13:0] exp_q[$];
  logic [3:0] nr_m;
  logic nf_m;
  always #5 clk_0 = ~clk_0;
  rule_scan_scheduler_if bus();
  rule_scan_scheduler #(.HOLD_CYC(HOLD), .DEFUZZ_LAT(LAT)) dut (.clk_0(clk_0), .Srst(Srst), .s(bus));
  wire [13:0] obs = {bus.Regras, bus.rule_valid, bus.Reset_inf, bus.EN_defuzzy,
                     bus.busy, bus.done, bus.no_fire, bus.n_rules};

  function automatic logic [13:0] pack(int r, int rv, int rinf, int edf, int busy, int done, int nf, int nr);
    return {r[3:0], rv[0], rinf[0], edf[0], busy[0], done[0], nf[0], nr[3:0]};
  endfunction

  task automatic check(input logic [13:0] e, input string tag);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic check1(input logic o, input logic e, input string tag);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // expected per-cycle outputs from cycle 1 (CLEAR) through DONE
  task automatic build(input logic [5:0] act);
    int cnt = 0;
    exp_q.delete();
    exp_q.push_back(pack(0, 0, 1, 0, 1, 0, 0, 0));
    for (int i1 = 0; i1 < 3; i1++)
      for (int i2 = 0; i2 < 3; i2++)
        if (act[i1] && act[3 + i2]) begin
          cnt++;
          repeat (HOLD) exp_q.push_back(pack(i1 * 4 + i2, 1, 0, 0, 1, 0, 0, cnt));
        end else exp_q.push_back(pack(i1 * 4 + i2, 0, 0, 0, 1, 0, 0, cnt));
    if (cnt > 0) begin
      exp_q.push_back(pack(0, 0, 0, 1, 1, 0, 0, cnt));
      repeat (LAT) exp_q.push_back(pack(0, 0, 0, 0, 1, 0, 0, cnt));
      exp_q.push_back(pack(0, 0, 0, 0, 1, 1, 0, cnt));
    end else exp_q.push_back(pack(0, 0, 0, 0, 1, 1, 1, 0));
    nr_m = 4'(cnt);
    nf_m = (cnt == 0);
  endtask

  // called at a negedge inside an IDLE cycle; returns at the negedge of the IDLE cycle after DONE
  task automatic run(input logic [5:0] act, input bit hold_en, input bit toggle, input string name);
    build(act);
    bus.Ativo_UP  = act;
    bus.EN_REGRAS = 1'b1;
    foreach (exp_q[k]) begin
      @(negedge clk_0);
      if (!hold_en) bus.EN_REGRAS = 1'($urandom);
      if (toggle) bus.Ativo_UP = 6'($urandom);
      check(exp_q[k], $sformatf("%s_c%0d", name, k + 1));
    end
    @(negedge clk_0);
    bus.EN_REGRAS = hold_en;
    check(pack(0, 0, 0, 0, 0, 0, nf_m, nr_m), {name, "_idle"});
  endtask

  initial begin
    bus.EN_REGRAS = 1'b0;
    bus.Ativo_UP  = '0;
`ifdef FUZZY_SCHED_ABORT_EN
    bus.abort = 1'b0;
`endif
    #1 Srst = 1'b0;
    #1 check(pack(0, 0, 0, 0, 0, 0, 0, 0), "reset");
    repeat (3) @(negedge clk_0);
    Srst = 1'b1;
    bus.EN_REGRAS = 1'b1;
    bus.Ativo_UP  = 6'b011011;
    @(negedge clk_0);
    check(pack(0, 0, 0, 0, 0, 0, 0, 0), "release_sync");
    bus.EN_REGRAS = 1'b0;
    repeat (3) @(negedge clk_0);
    run(6'b011011, 0, 0, "r031");
    run(6'b000111, 0, 0, "r032");
    run(6'b111111, 0, 0, "r033");
    run(6'b000111, 0, 1, "nofire_again");
    run(6'b101101, 1, 1, "r034a");
    run(6'b010110, 0, 1, "r034b");
    for (int n = 0; n < 12; n++) run(6'($urandom), 0, 1, $sformatf("rnd%0d", n));
    bus.Ativo_UP  = 6'b011011;
    bus.EN_REGRAS = 1'b1;
    repeat (6) @(negedge clk_0);
    bus.EN_REGRAS = 1'b0;
    check(pack(2, 0, 0, 0, 1, 0, 0, 2), "pre_rst_c6");
    #1 Srst = 1'b0;
    #1 check(pack(0, 0, 0, 0, 0, 0, 0, 0), "async_rst");
    @(negedge clk_0);
    Srst = 1'b1;
    repeat (3) @(negedge clk_0);
    run(6'b011011, 0, 0, "r035");
`ifdef FUZZY_SCHED_ABORT_EN
    bus.Ativo_UP  = 6'b111111;
    bus.EN_REGRAS = 1'b1;
    repeat (6) @(negedge clk_0);
    bus.EN_REGRAS = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk_0);
    bus.abort = 1'b0;
    check1(bus.busy, 1'b0, "abort_busy_c7");
    check1(bus.rule_valid, 1'b0, "abort_rv_c7");
    for (int c = 0; c < 30; c++) begin
      check1(bus.done | bus.EN_defuzzy, 1'b0, $sformatf("abort_quiet_%0d", c));
      @(negedge clk_0);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
